// File: rtl/smi_mux_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// smi_mux_if: SMI host bus plus per-channel fabric stream handshakes. Rev 1.0
// ----------------------------------------------------------------------------
interface smi_mux_if #(
  parameter int NCHAN = 4,
  parameter int DW    = 8
);
  logic [5:0]          i_smi_sa;
  logic                i_smi_wen;
  logic                i_smi_oen;
  logic [17:0]         i_smi_data;
  logic [17:0]         o_smi_data;
  logic                o_smi_oen;
  logic [NCHAN-1:0]    S_TX_VALID;
  logic [NCHAN-1:0]    S_TX_READY;
  logic [NCHAN*DW-1:0] S_TX_DATA;
  logic [NCHAN-1:0]    M_RX_VALID;
  logic [NCHAN-1:0]    M_RX_READY;
  logic [NCHAN*DW-1:0] M_RX_DATA;
  logic                o_int;

  modport slave (
    input  i_smi_sa, i_smi_wen, i_smi_oen, i_smi_data,
    input  S_TX_VALID, S_TX_DATA, M_RX_READY,
    output o_smi_data, o_smi_oen, S_TX_READY, M_RX_VALID, M_RX_DATA, o_int
  );

  modport master (
    output i_smi_sa, i_smi_wen, i_smi_oen, i_smi_data,
    output S_TX_VALID, S_TX_DATA, M_RX_READY,
    input  o_smi_data, o_smi_oen, S_TX_READY, M_RX_VALID, M_RX_DATA, o_int
  );
endinterface
`default_nettype wire

// File: rtl/smi_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// smi_mux: SMI host port bridged to NCHAN TX/RX stream FIFO pairs. Rev 1.0
// ----------------------------------------------------------------------------
module smi_mux #(
  parameter int NCHAN  = 4,
  parameter int DW     = 8,
  parameter int LGFIFO = 4
) (
  input wire       i_clk,
  input wire       i_reset_n,
  smi_mux_if.slave bus
);
  localparam int DEPTH = 1 << LGFIFO;
  localparam int CW    = LGFIFO + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [5:0]  sa_m, sa_s;
  logic [17:0] din_m, din_s;
  logic        wen_m, wen_s, oen_m, oen_s;
  logic        wen_d, oen_d;
  logic [1:0]  settle;
  logic        ready_en;
  logic        wr_active, rd_active, rd_pop, rd_status;
  logic [3:0]  wr_sa;
  logic [DW-1:0] wr_data;
  logic [2:0]  rd_chan;
  logic [17:0] smi_data_q;
  logic        smi_oen_q;

  logic [CW-1:0] tx_count [NCHAN];
  logic [DW-1:0] tx_head  [NCHAN];
  logic [NCHAN-1:0] tx_empty, rx_full, ovf, tx_ready, rx_valid;
  logic [NCHAN-1:0] tx_pop, rx_push, ovf_set, ovf_clr;
  logic [17:0] rd_word;

  logic edges_ok, both_low, wen_fall, wen_rise, oen_fall, oen_rise;
  logic do_write, do_latch, do_rdend;
  logic unused_bits;

  assign unused_bits = ^{sa_s[5:4], din_s};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sa_m  <= '0;   sa_s  <= '0;
      din_m <= '0;   din_s <= '0;
      wen_m <= 1'b1; wen_s <= 1'b1;
      oen_m <= 1'b1; oen_s <= 1'b1;
    end else begin
      sa_m  <= bus.i_smi_sa;   sa_s  <= sa_m;
      din_m <= bus.i_smi_data; din_s <= din_m;
      wen_m <= bus.i_smi_wen;  wen_s <= wen_m;
      oen_m <= bus.i_smi_oen;  oen_s <= oen_m;
    end
  end

  // Edges are ignored until the synchronizer and edge history both hold
  // post-reset pin values, so a strobe low at release never looks like an edge.
  assign edges_ok = (settle == 2'd3);
  assign both_low = ~wen_s & ~oen_s;
  assign wen_fall = edges_ok &  wen_d & ~wen_s;
  assign wen_rise = edges_ok & ~wen_d &  wen_s;
  assign oen_fall = edges_ok &  oen_d & ~oen_s;
  assign oen_rise = edges_ok & ~oen_d &  oen_s;
  assign do_write = wen_rise & wr_active;
  assign do_latch = oen_fall & ~both_low;
  assign do_rdend = oen_rise & rd_active;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (sa_s[2:0] == 3'(k)) begin
        if (sa_s[3]) begin
          rd_word[17]   = tx_empty[k];
          rd_word[16]   = rx_full[k];
          rd_word[15]   = ovf[k];
          rd_word[10:0] = 11'(tx_count[k]);
        end else if (!tx_empty[k]) begin
          rd_word[17]     = 1'b1;
          rd_word[DW-1:0] = tx_head[k];
        end
      end
    end
  end

  always_comb begin
    rx_push = '0;
    ovf_set = '0;
    tx_pop  = '0;
    ovf_clr = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (do_write && !wr_sa[3] && wr_sa[2:0] == 3'(k)) begin
        if (rx_full[k]) ovf_set[k] = 1'b1;
        else            rx_push[k] = 1'b1;
      end
      if (do_rdend && rd_chan == 3'(k)) begin
        tx_pop[k]  = rd_pop;
        ovf_clr[k] = rd_status;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      settle     <= 2'd0;
      ready_en   <= 1'b0;
      wen_d      <= 1'b1;
      oen_d      <= 1'b1;
      wr_active  <= 1'b0;
      rd_active  <= 1'b0;
      rd_pop     <= 1'b0;
      rd_status  <= 1'b0;
      rd_chan    <= '0;
      wr_sa      <= '0;
      wr_data    <= '0;
      smi_data_q <= '0;
      smi_oen_q  <= 1'b1;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      ready_en <= 1'b1;
      wen_d    <= wen_s;
      oen_d    <= oen_s;
      if (!wen_s) begin
        wr_sa   <= sa_s[3:0];
        wr_data <= din_s[DW-1:0];
      end
      if (both_low) begin
        wr_active <= 1'b0;
        rd_active <= 1'b0;
        smi_oen_q <= 1'b1;
      end else begin
        if (wen_fall)      wr_active <= 1'b1;
        else if (wen_rise) wr_active <= 1'b0;
        if (do_latch) begin
          rd_active  <= 1'b1;
          smi_data_q <= rd_word;
          smi_oen_q  <= 1'b0;
          rd_chan    <= sa_s[2:0];
          rd_status  <= sa_s[3];
          rd_pop     <= ~sa_s[3] & rd_word[17];
        end else if (oen_rise) begin
          rd_active <= 1'b0;
          smi_oen_q <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    logic [DW-1:0]     tx_mem [DEPTH];
    logic [DW-1:0]     rx_mem [DEPTH];
    logic [LGFIFO-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic              tx_push, rx_pop, ovf_q;

    assign tx_push = bus.S_TX_VALID[k] & tx_ready[k];
    assign rx_pop  = rx_valid[k] & bus.M_RX_READY[k];

    always_ff @(posedge i_clk) begin
      if (tx_push)    tx_mem[tx_wp] <= bus.S_TX_DATA[k*DW +: DW];
      if (rx_push[k]) rx_mem[rx_wp] <= wr_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        tx_wp  <= '0; tx_rp <= '0; tx_cnt <= '0;
        rx_wp  <= '0; rx_rp <= '0; rx_cnt <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (tx_push)    tx_wp <= tx_wp + LGFIFO'(1);
        if (tx_pop[k])  tx_rp <= tx_rp + LGFIFO'(1);
        if (rx_push[k]) rx_wp <= rx_wp + LGFIFO'(1);
        if (rx_pop)     rx_rp <= rx_rp + LGFIFO'(1);
        case ({tx_push, tx_pop[k]})
          2'b10:   tx_cnt <= tx_cnt + CW'(1);
          2'b01:   tx_cnt <= tx_cnt - CW'(1);
          default: tx_cnt <= tx_cnt;
        endcase
        case ({rx_push[k], rx_pop})
          2'b10:   rx_cnt <= rx_cnt + CW'(1);
          2'b01:   rx_cnt <= rx_cnt - CW'(1);
          default: rx_cnt <= rx_cnt;
        endcase
        if (ovf_set[k])      ovf_q <= 1'b1;
        else if (ovf_clr[k]) ovf_q <= 1'b0;
      end
    end

    assign tx_count[k] = tx_cnt;
    assign tx_head[k]  = tx_mem[tx_rp];
    assign tx_empty[k] = (tx_cnt == '0);
    assign rx_full[k]  = (rx_cnt == FULL_CNT);
    assign ovf[k]      = ovf_q;
    assign tx_ready[k] = ready_en & (tx_cnt != FULL_CNT);
    assign rx_valid[k] = (rx_cnt != '0);
    assign bus.M_RX_DATA[k*DW +: DW] = rx_mem[rx_rp];
  end

  assign bus.S_TX_READY = tx_ready;
  assign bus.M_RX_VALID = rx_valid;
  assign bus.o_int      = ~&tx_empty;
  assign bus.o_smi_data = smi_data_q;
  assign bus.o_smi_oen  = smi_oen_q;
endmodule
`default_nettype wire

// File: doc/smi_mux.md
SMI_MUX -- requirements
Module: smi_mux

Interface
- REQ-001 The block SHALL take parameter NCHAN, default 4, giving the number of stream channels (1..8).
- REQ-002 The block SHALL take parameter DW, default 8, giving the payload bits per channel word (1..16).
- REQ-003 The block SHALL take parameter LGFIFO, default 4, giving log2 of each FIFO's depth (2..10).
- REQ-004 i_clk  in  1  sole clock.
- REQ-005 i_reset_n  in  1  reset, asynchronous assert, active-low.
- REQ-006 i_smi_sa  in  6  SMI address: sa[2:0] = channel, sa[3] = 0 data / 1 status, sa[5:4] ignored.
- REQ-007 i_smi_wen, i_smi_oen  in  1 each  SMI write/read strobes, active-low, asynchronous to i_clk.
- REQ-008 i_smi_data  in  18  SMI bus input (asynchronous).
- REQ-009 o_smi_data  out  18  SMI read data.
- REQ-010 o_smi_oen  out  1  bus output enable; 1 = tri-state, 0 = drive.
- REQ-011 S_TX_VALID / S_TX_READY  in / out  NCHAN  per-channel fabric-to-host stream handshake.
- REQ-012 S_TX_DATA  in  NCHAN*DW  fabric-to-host stream data; channel k occupies bits [k*DW +: DW].
- REQ-013 M_RX_VALID / M_RX_READY  out / in  NCHAN  per-channel host-to-fabric stream handshake.
- REQ-014 M_RX_DATA  out  NCHAN*DW  host-to-fabric stream data, packed as for S_TX_DATA.
- REQ-015 o_int  out  1  asserted while any valid channel's TX FIFO is non-empty.

Function
- REQ-016 i_smi_sa, i_smi_wen, i_smi_oen and i_smi_data SHALL each pass through a 2-flop synchronizer; all decoding SHALL use only the synchronized copies.
- REQ-017 Each channel SHALL own one TX FIFO (fabric-to-host) and one RX FIFO (host-to-fabric), each of depth 2^LGFIFO, with fill counters LGFIFO+1 bits wide.
- REQ-018 S_TX_READY[k] SHALL equal "TX FIFO k not full"; a word is pushed when VALID && READY.
- REQ-019 M_RX_VALID[k] SHALL equal "RX FIFO k not empty", with M_RX_DATA showing the head word; the head is popped when VALID && READY.
- REQ-020 Write commit SHALL occur on the synchronized wen rising edge: the address and data sampled on the last cycle wen was low are used, and a data-address write to a valid channel pushes data[DW-1:0] into that channel's RX FIFO.
- REQ-021 A write to a full RX FIFO SHALL drop the word and set that channel's sticky overflow flag.
- REQ-022 Writes to the status address, or to any channel index >= NCHAN, SHALL be ignored.
- REQ-023 On the synchronized oen falling edge, the block SHALL latch a read word into o_smi_data and drive o_smi_oen = 0, exactly 3 i_clk edges after i_smi_oen falls.
- REQ-024 Read at a data address: a non-empty TX FIFO returns {1'b1, zero pad, head[DW-1:0]}; an empty one returns 18'h0.
- REQ-025 Read at a status address returns bit17 = TX empty, bit16 = RX full, bit15 = overflow, bits[10:0] = TX fill level (zero-extended).
- REQ-026 Reads of any channel index >= NCHAN SHALL return 18'h0.
- REQ-027 On the synchronized oen rising edge: o_smi_oen returns to 1, a data read that returned bit17 = 1 pops the TX head, and a status read clears the overflow flag.
- REQ-028 o_smi_data SHALL hold its value until the next read latch.
- REQ-029 If synchronized wen and oen are both low, the block SHALL take no FIFO or flag action and SHALL keep o_smi_oen = 1.
- REQ-030 A simultaneous fabric push and host pop on the same FIFO SHALL both take effect, leaving the fill level unchanged.
- REQ-031 Host accesses to different channels SHALL have no effect on the other channels' streams.
- REQ-032 FIFO pointers SHALL wrap modulo 2^LGFIFO; full is defined as fill == 2^LGFIFO.

Reset
- REQ-033 While i_reset_n = 0 the block SHALL hold: all FIFOs empty, overflow flags cleared, synchronizers set to strobes-inactive (1).
- REQ-034 While i_reset_n = 0 the outputs SHALL be: o_smi_oen = 1, o_smi_data = 0, M_RX_VALID = 0, S_TX_READY = 0, o_int = 0.
- REQ-035 S_TX_READY SHALL rise on the first clock after reset is released.
- REQ-036 A reset asserted during an SMI strobe SHALL abort the access with no side effects after release; a strobe still low at release SHALL NOT be treated as an edge.

Verification
- REQ-037 Host write 0x0A5 to sa = 0x01 -> within 5 clocks of wen rising, M_RX_VALID = 4'b0010 and M_RX_DATA[15:8] = 0xA5.
- REQ-038 Fabric pushes 0x3C on channel 2, then host reads sa = 0x02 -> o_smi_data = 0x2003C, o_smi_oen = 0 3 clocks after oen falls; a second read returns 0x00000.
- REQ-039 With LGFIFO = 2 and M_RX_READY = 0, write 5 words to channel 0 -> 4 are retained; status read of sa = 0x08 shows bit16 = 1 and bit15 = 1; the next status read shows bit15 = 0.
- REQ-040 Push and pop channel 3's TX FIFO on the same clock at fill = 2 -> fill stays 2, and the status fill field reads 2.
- REQ-041 wen and oen both low for 10 clocks -> no FIFO change and o_smi_oen stays 1; assert reset mid-read -> o_smi_oen = 1 immediately and all FIFOs empty.
